pfd_offset_cal_sched: RTL and testbench
=======================================

// Module: pfd_offset_cal_sched
// PURPOSE
//  Sequences PFD offset calibration across all time-interleaved ADC slices, one slice at a time.
//  Per slice: wait a settle window, accumulate 2**n_avg valid ADC samples, take the mean, step the
//  slice offset against the mean with saturation, then advance to the next slice. Repeats n_pass sweeps.
//  Sits in the digital core between the ADC output bus and the external PFD offset path.
//  JTAG supplies the start, abort and config fields; the offset outputs and status read back over JTAG.
// PARAMETERS
//  Nti     16  number of interleaved ADC slices
//  Nadc    8   ADC word / offset width (signed)
//  Nrange  4   width of n_avg; max averaging 2**(2**Nrange-1) samples
// PORTS
//  clk            in   1          core clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          1-cycle pulse: begin calibration (ignored while busy)
//  abort          in   1          level: return to IDLE at next edge, offsets hold
//  n_avg          in   Nrange     log2 of samples averaged per slice (latched at start)
//  n_pass         in   4          sweeps over all slices, 0 treated as 1 (latched at start)
//  settle_cycles  in   8          idle cycles after slice select before accumulating (latched)
//  flip_feedback  in   1          1: offset += mean; 0: offset -= mean (latched)
//  adc_valid      in   1          adcout carries a new sample set this cycle
//  adcout         in   Nti*Nadc   signed ADC words, slice k at [k*Nadc +: Nadc]
//  pfd_offset     out  Nti*Nadc   signed offsets, slice k at [k*Nadc +: Nadc]
//  cal_valid      out  1          high once one full sweep has completed since reset
//  busy           out  1          high in every state other than IDLE
//  done           out  1          1-cycle pulse on completion of the last sweep
//  cur_slice      out  $clog2(Nti) slice currently being calibrated
// BEHAVIOUR
//  Reset: all pfd_offset = 0, cal_valid=0, busy=0, done=0, cur_slice=0, acc=0, state=IDLE.
//  FSM: IDLE -> SETTLE -> ACCUM -> UPDATE -> (SETTLE | DONE) -> IDLE.
//   IDLE: on start, latch the config fields, cur_slice=0, pass=0, and go to SETTLE.
//   SETTLE: count settle_cycles clocks; 0 means go straight to ACCUM the next cycle. Clear acc.
//   ACCUM: on each adc_valid, acc += sign-extended adcout[cur_slice]; count samples.
//    After 2**n_avg valid samples, go to UPDATE. adc_valid low stalls the count with no timeout.
//   UPDATE (1 cycle): mean = acc >>> n_avg (arithmetic shift, truncates toward -inf).
//    new = offset +/- mean, computed at Nadc+1 bits and saturated to [-2**(Nadc-1), 2**(Nadc-1)-1].
//    new is written to pfd_offset[cur_slice] on this edge.
//    If cur_slice < Nti-1: cur_slice++ and go to SETTLE.
//    Else: cur_slice=0, cal_valid=1, pass++; if pass == n_pass go to DONE, else go to SETTLE.
//   DONE (1 cycle): done=1, then IDLE.
//  acc width is Nadc + 2**Nrange - 1 bits and cannot overflow at max n_avg.
//  Only the slice being calibrated changes; the other offsets hold.
//  abort or rst mid-run: abort goes to IDLE with no done pulse and keeps the offsets written so far.
//   rst clears everything.
//  abort and start in the same cycle: abort wins.
//  start while busy: ignored.
//  Config inputs changing mid-run: no effect until the next start.
//  Latency per slice = 1 (SETTLE entry) + settle_cycles + valid-sample cycles + 1 (UPDATE).
// TESTING
//  1. Nti=16, n_avg=2, n_pass=1, settle=0, all slices constant +4, flip=0 -> every offset=-4,
//     done once, cal_valid=1.
//  2. Slice 3 = +100, the rest 0, n_pass=2, flip=0 -> offset[3]=-128 (saturated), others 0.
//     With flip=1 -> +127.
//  3. n_avg=3, adc_valid toggling every other cycle, slice samples {-1,-2} alternating
//     -> mean=-2 (floor), offset=+2.
//     ACCUM lasts 16 cycles per slice.
//  4. Assert abort while cur_slice=5 -> busy drops the next cycle, no done.
//     Offsets 0..4 updated, 5..15 unchanged.
//  5. start pulsed while busy, and start+abort in the same cycle -> no restart, FSM goes IDLE.
//  6. Assert rst mid-ACCUM -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pfd_offset_cal_sched_if.sv
// Purpose: bundles the calibration scheduler's control, ADC input and offset/status buses.
// Ports  : master drives start/abort/config and the ADC sample bus, and reads offsets/status;
//          slave is the scheduler side.
interface pfd_offset_cal_sched_if #(
    parameter int Nti    = 16,
    parameter int Nadc   = 8,
    parameter int Nrange = 4
);
    logic                      start;
    logic                      abort;
    logic [Nrange-1:0]         n_avg;
    logic [3:0]                n_pass;
    logic [7:0]                settle_cycles;
    logic                      flip_feedback;
    logic                      adc_valid;
    logic [Nti*Nadc-1:0]       adcout;
    logic [Nti*Nadc-1:0]       pfd_offset;
    logic                      cal_valid;
    logic                      busy;
    logic                      done;
    logic [$clog2(Nti)-1:0]    cur_slice;

    modport master (
        output start, abort, n_avg, n_pass, settle_cycles, flip_feedback, adc_valid, adcout,
        input  pfd_offset, cal_valid, busy, done, cur_slice
    );

    modport slave (
        input  start, abort, n_avg, n_pass, settle_cycles, flip_feedback, adc_valid, adcout,
        output pfd_offset, cal_valid, busy, done, cur_slice
    );
endinterface

// File: rtl/pfd_offset_cal_sched.sv
// Purpose : sequences PFD offset calibration over all interleaved ADC slices, n_pass sweeps.
// Latency : per slice 1 + settle_cycles + (cycles to collect 2**n_avg valid samples) + 1.
// Backpressure: none; adc_valid low simply stalls accumulation, abort returns to IDLE next edge.
// Ports   : clk, rst (sync, active high); bus (slave) carries start/abort/config, the ADC
//           sample set, and the offset/status outputs.
module pfd_offset_cal_sched #(
    parameter int Nti    = 16,
    parameter int Nadc   = 8,
    parameter int Nrange = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pfd_offset_cal_sched_if.slave bus
);
    localparam int SW    = $clog2(Nti);
    localparam int CNT_W = 2**Nrange - 1;
    localparam int ACC_W = Nadc + CNT_W;
    localparam int OW    = Nadc + 1;
    localparam logic signed [OW-1:0] SAT_HI = OW'(2**(Nadc-1) - 1);
    localparam logic signed [OW-1:0] SAT_LO = OW'(-(2**(Nadc-1)));

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_UPDATE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [Nrange-1:0]        n_avg_l;
    logic [3:0]               n_pass_l;
    logic [7:0]               settle_l;
    logic                     flip_l;
    logic [7:0]               settle_cnt;
    logic [CNT_W-1:0]         smp_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic [3:0]               pass_cnt;
    logic [SW-1:0]            cur;
    logic                     cal_valid_q;
    logic signed [Nadc-1:0]   off_q [Nti];

    logic                     start_go;
    logic [CNT_W-1:0]         smp_target;
    logic                     smp_last;
    logic                     slice_last;
    logic                     pass_last;
    logic signed [Nadc-1:0]   sample;
    logic signed [Nadc-1:0]   off_cur;
    logic signed [Nadc-1:0]   mean;
    logic signed [OW-1:0]     sum;
    logic signed [Nadc-1:0]   new_off;

    // abort outranks start, so a simultaneous pair never launches a run
    assign start_go   = bus.start && !bus.abort;
    // 2**n_avg - 1 as a right-shifted all-ones mask: index of the final sample
    assign smp_target = {CNT_W{1'b1}} >> (Nrange'(CNT_W) - n_avg_l);
    assign smp_last   = (smp_cnt == smp_target);
    assign slice_last = (cur == SW'(Nti - 1));
    assign pass_last  = ((pass_cnt + 4'd1) == n_pass_l);

    assign sample  = bus.adcout[cur*Nadc +: Nadc];
    assign off_cur = off_q[cur];
    // Mean of Nadc-bit samples always fits in Nadc bits, so truncation is exact
    assign mean    = Nadc'(acc >>> n_avg_l);
    // One extra bit holds any offset +/- mean; clamp back into the Nadc range
    assign sum     = flip_l ? (OW'(off_cur) + OW'(mean)) : (OW'(off_cur) - OW'(mean));
    assign new_off = (sum > SAT_HI) ? Nadc'(SAT_HI) :
                     (sum < SAT_LO) ? Nadc'(SAT_LO) : sum[Nadc-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.start) state_nxt = S_SETTLE;
                S_SETTLE: if (settle_cnt == settle_l) state_nxt = S_ACCUM;
                S_ACCUM:  if (bus.adc_valid && smp_last) state_nxt = S_UPDATE;
                S_UPDATE: state_nxt = (slice_last && pass_last) ? S_DONE : S_SETTLE;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.done      = (state == S_DONE);
        bus.cal_valid = cal_valid_q;
        bus.cur_slice = cur;
        bus.pfd_offset = '0;
        for (int k = 0; k < Nti; k++) bus.pfd_offset[k*Nadc +: Nadc] = off_q[k];
    end

    // Datapath freezes while abort is high; everything written so far is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            n_avg_l     <= '0;
            n_pass_l    <= 4'd1;
            settle_l    <= '0;
            flip_l      <= 1'b0;
            settle_cnt  <= '0;
            smp_cnt     <= '0;
            acc         <= '0;
            pass_cnt    <= '0;
            cur         <= '0;
            cal_valid_q <= 1'b0;
            for (int k = 0; k < Nti; k++) off_q[k] <= '0;
        end else if (!bus.abort) begin
            case (state)
                S_IDLE: begin
                    if (start_go) begin
                        n_avg_l    <= bus.n_avg;
                        n_pass_l   <= (bus.n_pass == 4'd0) ? 4'd1 : bus.n_pass;
                        settle_l   <= bus.settle_cycles;
                        flip_l     <= bus.flip_feedback;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                        cur        <= '0;
                    end
                end
                S_SETTLE: begin
                    acc        <= '0;
                    smp_cnt    <= '0;
                    settle_cnt <= settle_cnt + 8'd1;
                end
                S_ACCUM: begin
                    if (bus.adc_valid) begin
                        acc     <= acc + ACC_W'(sample);
                        smp_cnt <= smp_cnt + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    off_q[cur] <= new_off;
                    settle_cnt <= '0;
                    if (slice_last) begin
                        cur         <= '0;
                        cal_valid_q <= 1'b1;
                        pass_cnt    <= pass_cnt + 4'd1;
                    end else begin
                        cur <= cur + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pfd_offset_cal_sched.sv
module tb_pfd_offset_cal_sched;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pfd_offset_cal_sched_if #(.Nti(16), .Nadc(8), .Nrange(4)) ifc ();
    pfd_offset_cal_sched #(.Nti(16), .Nadc(8), .Nrange(4)) dut (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct packed {
        logic [31:0]  id;
        logic [127:0] off;
        logic         cal;
        logic         chk_cur;
        logic         chk_cyc;
        logic [31:0]  cyc;
        logic [31:0]  dones;
    } exp_t;

    exp_t q[$];

    function automatic logic [127:0] mk_off(input logic [7:0] base, input int lo, input int hi,
                                            input logic [7:0] val);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = (k >= lo && k <= hi) ? val : base;
        return r;
    endfunction

    function automatic exp_t mk(input int id, input logic [127:0] off, input bit cal,
                                input bit chk_cur, input bit chk_cyc, input int c, input int dones);
        exp_t e;
        e.id = id; e.off = off; e.cal = cal; e.chk_cur = chk_cur;
        e.chk_cyc = chk_cyc; e.cyc = c; e.dones = dones;
        return e;
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor: pops one expectation per end-of-run event ----------------
    logic prev_busy = 1'b0;
    logic prev_rst  = 1'b0;
    int   done_cnt  = 0;

    always @(negedge clk) begin
        exp_t e;
        if ((prev_busy === 1'b1 && ifc.busy === 1'b0) || (prev_rst === 1'b1 && rst === 1'b0)) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: busy fell or reset released at cycle %0d, none expected", cyc);
            end else begin
                e = q.pop_front();
                chk($sformatf("t%0d_done_pulses", e.id), done_cnt, e.dones);
                chk($sformatf("t%0d_cal_valid", e.id), 32'(ifc.cal_valid), 32'(e.cal));
                chk($sformatf("t%0d_busy", e.id), 32'(ifc.busy), 0);
                chk($sformatf("t%0d_done", e.id), 32'(ifc.done), 0);
                if (e.chk_cur) chk($sformatf("t%0d_cur_slice", e.id), 32'(ifc.cur_slice), 0);
                if (e.chk_cyc) chk($sformatf("t%0d_end_cycle", e.id), cyc, e.cyc);
                for (int k = 0; k < 16; k++)
                    chk($sformatf("t%0d_offset%0d", e.id, k),
                        $signed(ifc.pfd_offset[k*8 +: 8]), $signed(e.off[k*8 +: 8]));
            end
            done_cnt = 0;
        end
        if (ifc.done === 1'b1) done_cnt++;
        prev_busy = ifc.busy;
        prev_rst  = rst;
    end

    // ---------------- ADC sample driver ----------------
    int         adc_mode = 0;
    logic [7:0] cval = 8'sd4;
    int         sidx = 0;

    initial begin
        ifc.adc_valid = 1'b1;
        ifc.adcout    = '0;
        forever begin
            @(posedge clk); #1;
            case (adc_mode)
                0: begin
                    ifc.adc_valid = 1'b1;
                    for (int k = 0; k < 16; k++) ifc.adcout[k*8 +: 8] = cval;
                end
                1: begin
                    ifc.adc_valid = 1'b1;
                    ifc.adcout = '0;
                    ifc.adcout[3*8 +: 8] = 8'sd100;
                end
                default: begin
                    ifc.adc_valid = cyc[0];
                    if (cyc[0]) begin
                        for (int k = 0; k < 16; k++) ifc.adcout[k*8 +: 8] = sidx[0] ? -8'sd2 : -8'sd1;
                        sidx++;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    // Caller sits just after a rising edge; k is the cycle in which the pulse is seen.
    task automatic issue(input bit s, input bit a, output int k);
        ifc.start = s; ifc.abort = a; k = cyc;
        @(posedge clk); #1;
        ifc.start = 1'b0; ifc.abort = 1'b0;
    endtask

    task automatic do_reset(input bit running);
        if (running) q.push_back(mk(0, '0, 1'b0, 1'b1, 1'b0, 0, 0));
        q.push_back(mk(0, '0, 1'b0, 1'b1, 1'b0, 0, 0));
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("pending_expectations", q.size(), 0);
    endtask

    task automatic wait_cur(input int s);
        bit hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (ifc.cur_slice == 4'(s)) begin hit = 1'b1; break; end
        end
        chk($sformatf("reach_slice%0d", s), 32'(hit), 1);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        ifc.start = 1'b0; ifc.abort = 1'b0;
        ifc.n_avg = 4'd2; ifc.n_pass = 4'd1; ifc.settle_cycles = 8'd0; ifc.flip_feedback = 1'b0;

        do_reset(1'b0);
        wait_drain(50);

        // 1: constant +4, n_avg=2, one pass, no settle -> all -4
        issue(1'b1, 1'b0, k);
        q.push_back(mk(1, mk_off(8'h00, 0, 15, -8'sd4), 1'b1, 1'b1, 1'b1, k + 2 + 16*6, 1));
        wait_drain(500);

        // 2a: slice 3 = +100, two passes, settle 5 -> slice 3 saturates at -128
        do_reset(1'b0); wait_drain(50);
        adc_mode = 1; ifc.n_pass = 4'd2; ifc.settle_cycles = 8'd5;
        issue(1'b1, 1'b0, k);
        q.push_back(mk(2, mk_off(8'h00, 3, 3, 8'h80), 1'b1, 1'b1, 1'b1, k + 2 + 2*16*11, 1));
        wait_drain(1000);

        // 2b: same with flip -> +127
        do_reset(1'b0); wait_drain(50);
        ifc.flip_feedback = 1'b1; ifc.settle_cycles = 8'd0;
        issue(1'b1, 1'b0, k);
        q.push_back(mk(3, mk_off(8'h00, 3, 3, 8'sd127), 1'b1, 1'b1, 1'b1, k + 2 + 2*16*6, 1));
        wait_drain(1000);

        // 3: n_avg=3, valid every other cycle, samples -1/-2 -> mean -2, offset +2;
        //    n_pass=0 behaves as one pass; a start mid-run is ignored
        do_reset(1'b0); wait_drain(50);
        ifc.flip_feedback = 1'b0; ifc.n_pass = 4'd0; ifc.n_avg = 4'd3; adc_mode = 2;
        @(posedge clk); #1;
        if (cyc[0]) begin @(posedge clk); #1; end
        issue(1'b1, 1'b0, k);
        q.push_back(mk(4, mk_off(8'h00, 0, 15, 8'sd2), 1'b1, 1'b1, 1'b1, k + 2 + 16*18, 1));
        wait_cur(7);
        issue(1'b1, 1'b0, k);
        wait_drain(1000);

        // 5: start+abort together mid-run -> IDLE, slices 0..1 updated (2-4=-2), rest hold +2
        adc_mode = 0; cval = 8'sd4; ifc.n_avg = 4'd2; ifc.n_pass = 4'd1;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, k);
        wait_cur(2);
        issue(1'b1, 1'b1, k);
        q.push_back(mk(5, mk_off(8'sd2, 0, 1, -8'sd2), 1'b1, 1'b0, 1'b1, k + 1, 0));
        wait_drain(50);
        // start+abort from IDLE must not launch anything
        issue(1'b1, 1'b1, k);
        repeat (120) @(posedge clk);
        #1;

        // 4: abort at slice 5 -> busy drops next cycle, slices 0..4 = -4; config changes ignored
        do_reset(1'b0); wait_drain(50);
        issue(1'b1, 1'b0, k);
        ifc.n_avg = 4'd3; ifc.n_pass = 4'd5; ifc.flip_feedback = 1'b1; ifc.settle_cycles = 8'd9;
        wait_cur(5);
        issue(1'b0, 1'b1, k);
        q.push_back(mk(6, mk_off(8'h00, 0, 4, -8'sd4), 1'b0, 1'b0, 1'b1, k + 1, 0));
        wait_drain(50);
        ifc.n_avg = 4'd2; ifc.n_pass = 4'd1; ifc.flip_feedback = 1'b0; ifc.settle_cycles = 8'd0;

        // 6: reset mid-ACCUM of slice 3 -> everything back to reset values
        @(posedge clk); #1;
        issue(1'b1, 1'b0, k);
        wait_cur(3);
        @(posedge clk); #1;
        do_reset(1'b1);
        wait_drain(50);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
